// File: rtl/mbus_tx_queue.sv
// Host-to-MBus TX queue: stores words and replays each message over the wrapper's REQ/ACK and response handshakes.
// TX_REQ rises one edge after a stored message (or a full FIFO) is seen in IDLE; IN_READY is low only when full with no pop.
module mbus_tx_queue #(
  parameter int DEPTH      = 8,
  parameter int CNT_WIDTH  = 8,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  CLK_EXT,
  input  logic                  RESETn,
  input  logic                  IN_VALID,
  output logic                  IN_READY,
  input  logic [ADDR_WIDTH-1:0] IN_ADDR,
  input  logic [DATA_WIDTH-1:0] IN_DATA,
  input  logic                  IN_LAST,
  input  logic                  IN_PRIORITY,
  output logic [ADDR_WIDTH-1:0] TX_ADDR,
  output logic [DATA_WIDTH-1:0] TX_DATA,
  output logic                  TX_PEND,
  output logic                  TX_REQ,
  output logic                  PRIORITY,
  input  logic                  TX_ACK,
  input  logic                  TX_SUCC,
  input  logic                  TX_FAIL,
  output logic                  TX_RESP_ACK,
  output logic                  BUSY,
  output logic                  MSG_DONE,
  output logic                  MSG_FAIL,
  output logic [CNT_WIDTH-1:0]  SUCC_CNT,
  output logic [CNT_WIDTH-1:0]  FAIL_CNT
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam logic [PW-1:0]        PONE = PW'(1);
  localparam logic [PW-1:0]        PFULL = PW'(DEPTH);
  localparam logic [CNT_WIDTH-1:0] CONE = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] CMAX = '1;

  typedef enum logic [2:0] {S_IDLE, S_REQ, S_ACKLOW, S_RESP, S_RACK, S_FLUSH} state_t;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data;
    logic                  last;
    logic                  prio;
  } entry_t;

  entry_t        mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q, count_q, msg_cnt_q;
  logic [PW-1:0] count_d, msg_cnt_d;
  entry_t        head;
  logic          full, empty, push, pop;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] tx_addr_q, tx_addr_d;
  logic [DATA_WIDTH-1:0] tx_data_q, tx_data_d;
  logic                  tx_pend_q, tx_pend_d;
  logic                  tx_req_q, tx_req_d;
  logic                  prio_q, prio_d;
  logic                  resp_ack_q, resp_ack_d;
  logic                  fail_q, fail_d;
  logic                  last_pop_q, last_pop_d;
  logic                  done_q, done_d;
  logic                  msg_fail_q, msg_fail_d;
  logic [CNT_WIDTH-1:0]  succ_cnt_q, succ_cnt_d;
  logic [CNT_WIDTH-1:0]  fail_cnt_q, fail_cnt_d;

  assign full     = (count_q == PFULL);
  assign empty    = (count_q == '0);
  assign head     = mem_q[rd_ptr_q[AW-1:0]];
  assign IN_READY = ~full | pop;
  assign push     = IN_VALID & IN_READY;

  always_ff @(posedge CLK_EXT) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= '{addr: IN_ADDR, data: IN_DATA, last: IN_LAST, prio: IN_PRIORITY};
  end

  always_comb begin
    count_d   = count_q;
    msg_cnt_d = msg_cnt_q;
    if (push) count_d = count_d + PONE;
    if (pop)  count_d = count_d - PONE;
    if (push && IN_LAST)   msg_cnt_d = msg_cnt_d + PONE;
    if (pop && head.last)  msg_cnt_d = msg_cnt_d - PONE;
  end

  always_comb begin
    state_d    = state_q;
    tx_addr_d  = tx_addr_q;
    tx_data_d  = tx_data_q;
    tx_pend_d  = tx_pend_q;
    tx_req_d   = tx_req_q;
    prio_d     = prio_q;
    resp_ack_d = resp_ack_q;
    fail_d     = fail_q;
    last_pop_d = last_pop_q;
    done_d     = 1'b0;
    msg_fail_d = 1'b0;
    succ_cnt_d = succ_cnt_q;
    fail_cnt_d = fail_cnt_q;
    pop        = 1'b0;
    case (state_q)
      S_IDLE: begin
        // A full FIFO starts transmission so messages longer than DEPTH can drain.
        if (msg_cnt_q != '0 || full) begin
          tx_addr_d  = head.addr;
          prio_d     = head.prio;
          tx_data_d  = head.data;
          tx_pend_d  = ~head.last;
          tx_req_d   = 1'b1;
          fail_d     = 1'b0;
          last_pop_d = 1'b0;
          state_d    = S_REQ;
        end
      end
      S_REQ, S_ACKLOW: begin
        if (TX_FAIL) begin
          tx_req_d   = 1'b0;
          fail_d     = 1'b1;
          resp_ack_d = 1'b1;
          state_d    = S_RACK;
        end else if (state_q == S_REQ) begin
          if (TX_ACK) begin
            pop        = 1'b1;
            tx_req_d   = 1'b0;
            last_pop_d = head.last;
            state_d    = S_ACKLOW;
          end
        end else if (!TX_ACK) begin
          if (last_pop_q) begin
            state_d = S_RESP;
          end else if (!empty) begin
            tx_data_d = head.data;
            tx_pend_d = ~head.last;
            tx_req_d  = 1'b1;
            state_d   = S_REQ;
          end
        end
      end
      S_RESP: begin
        if (TX_SUCC || TX_FAIL) begin
          fail_d     = TX_FAIL;
          resp_ack_d = 1'b1;
          state_d    = S_RACK;
        end
      end
      S_RACK: begin
        if (!TX_SUCC && !TX_FAIL) begin
          resp_ack_d = 1'b0;
          if (fail_q && !last_pop_q) begin
            state_d = S_FLUSH;
          end else begin
            done_d     = 1'b1;
            msg_fail_d = fail_q;
            state_d    = S_IDLE;
          end
        end
      end
      S_FLUSH: begin
        if (!empty) begin
          pop = 1'b1;
          if (head.last) begin
            done_d     = 1'b1;
            msg_fail_d = 1'b1;
            state_d    = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (done_d && msg_fail_d && fail_cnt_q != CMAX)  fail_cnt_d = fail_cnt_q + CONE;
    if (done_d && !msg_fail_d && succ_cnt_q != CMAX) succ_cnt_d = succ_cnt_q + CONE;
  end

  always_ff @(posedge CLK_EXT or negedge RESETn) begin
    if (!RESETn) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      msg_cnt_q  <= '0;
      state_q    <= S_IDLE;
      tx_addr_q  <= '0;
      tx_data_q  <= '0;
      tx_pend_q  <= 1'b0;
      tx_req_q   <= 1'b0;
      prio_q     <= 1'b0;
      resp_ack_q <= 1'b0;
      fail_q     <= 1'b0;
      last_pop_q <= 1'b0;
      done_q     <= 1'b0;
      msg_fail_q <= 1'b0;
      succ_cnt_q <= '0;
      fail_cnt_q <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PONE;
      if (pop)  rd_ptr_q <= rd_ptr_q + PONE;
      count_q    <= count_d;
      msg_cnt_q  <= msg_cnt_d;
      state_q    <= state_d;
      tx_addr_q  <= tx_addr_d;
      tx_data_q  <= tx_data_d;
      tx_pend_q  <= tx_pend_d;
      tx_req_q   <= tx_req_d;
      prio_q     <= prio_d;
      resp_ack_q <= resp_ack_d;
      fail_q     <= fail_d;
      last_pop_q <= last_pop_d;
      done_q     <= done_d;
      msg_fail_q <= msg_fail_d;
      succ_cnt_q <= succ_cnt_d;
      fail_cnt_q <= fail_cnt_d;
    end
  end

  assign TX_ADDR     = tx_addr_q;
  assign TX_DATA     = tx_data_q;
  assign TX_PEND     = tx_pend_q;
  assign TX_REQ      = tx_req_q;
  assign PRIORITY    = prio_q;
  assign TX_RESP_ACK = resp_ack_q;
  assign BUSY        = (state_q != S_IDLE);
  assign MSG_DONE    = done_q;
  assign MSG_FAIL    = msg_fail_q;
  assign SUCC_CNT    = succ_cnt_q;
  assign FAIL_CNT    = fail_cnt_q;
endmodule

// File: tb/tb_mbus_tx_queue.sv
// Bench for mbus_tx_queue: a wrapper model answers the TX handshakes; results are compared with a message-level model.
module tb_mbus_tx_queue;
  localparam int CW   = 2;
  localparam int CMAX = (1 << CW) - 1;

  logic        clk = 1'b0;
  logic        RESETn, IN_VALID, IN_READY, IN_LAST, IN_PRIORITY;
  logic [31:0] IN_ADDR, IN_DATA, TX_ADDR, TX_DATA;
  logic        TX_PEND, TX_REQ, PRIORITY, TX_ACK, TX_SUCC, TX_FAIL, TX_RESP_ACK;
  logic        BUSY, MSG_DONE, MSG_FAIL;
  logic [CW-1:0] SUCC_CNT, FAIL_CNT;

  mbus_tx_queue #(.DEPTH(8), .CNT_WIDTH(CW), .ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .CLK_EXT(clk), .RESETn(RESETn), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
    .IN_ADDR(IN_ADDR), .IN_DATA(IN_DATA), .IN_LAST(IN_LAST), .IN_PRIORITY(IN_PRIORITY),
    .TX_ADDR(TX_ADDR), .TX_DATA(TX_DATA), .TX_PEND(TX_PEND), .TX_REQ(TX_REQ), .PRIORITY(PRIORITY),
    .TX_ACK(TX_ACK), .TX_SUCC(TX_SUCC), .TX_FAIL(TX_FAIL), .TX_RESP_ACK(TX_RESP_ACK),
    .BUSY(BUSY), .MSG_DONE(MSG_DONE), .MSG_FAIL(MSG_FAIL), .SUCC_CNT(SUCC_CNT), .FAIL_CNT(FAIL_CNT)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic        pend;
    logic        prio;
  } word_t;

  int    errors = 0, checks = 0, tmo_cnt = 0, stab_err = 0, nobs = 0;
  int    succ_m = 0, fail_m = 0;
  word_t exp_q[$];
  word_t obs_w[32];
  bit    done_log[$];
  bit    in_msg = 0;
  logic [31:0] cur_addr;
  bit    cur_prio;

  always @(negedge clk) if (RESETn && MSG_DONE) done_log.push_back(MSG_FAIL);

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish, got running expected finished");
    $fatal(1, "watchdog");
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic model_clear();
    exp_q.delete(); done_log.delete(); in_msg = 0; succ_m = 0; fail_m = 0;
  endtask

  task automatic do_reset();
    RESETn = 1'b0; IN_VALID = 0; IN_LAST = 0; IN_PRIORITY = 0; IN_ADDR = '0; IN_DATA = '0;
    TX_ACK = 0; TX_SUCC = 0; TX_FAIL = 0;
    cyc(2);
    RESETn = 1'b1;
    model_clear();
    cyc(1);
  endtask

  // Offers one word until accepted; the model records what the wrapper should later see.
  task automatic push_word(input logic [31:0] a, input logic [31:0] d, input bit last, input bit prio);
    bit ok; int n; word_t w;
    IN_VALID = 1; IN_ADDR = a; IN_DATA = d; IN_LAST = last; IN_PRIORITY = prio;
    ok = 0; n = 0;
    while (!ok && n < 400) begin
      #4 ok = IN_READY;
      @(negedge clk);
      n++;
    end
    IN_VALID = 0;
    if (!ok) tmo_cnt++;
    else begin
      if (!in_msg) begin cur_addr = a; cur_prio = prio; end
      w.addr = cur_addr; w.data = d; w.pend = !last; w.prio = cur_prio;
      exp_q.push_back(w);
      in_msg = !last;
    end
  endtask

  task automatic wait_req(input logic lvl);
    int n; n = 0;
    while (TX_REQ !== lvl && n < 300) begin @(negedge clk); n++; end
    if (TX_REQ !== lvl) tmo_cnt++;
  endtask

  task automatic wait_rack(input logic lvl);
    int n; n = 0;
    while (TX_RESP_ACK !== lvl && n < 300) begin @(negedge clk); n++; end
    if (TX_RESP_ACK !== lvl) tmo_cnt++;
  endtask

  task automatic resp_hs();
    wait_rack(1'b1);
    cyc($urandom_range(0, 1));
    TX_SUCC = 0; TX_FAIL = 0;
    wait_rack(1'b0);
  endtask

  // Wrapper model: acks each REQ, fails early after word fail_after (0 = never), then responds.
  task automatic wrapper_serve(input int fail_after, input bit end_fail);
    bit fin; word_t w;
    nobs = 0; fin = 0;
    while (!fin) begin
      wait_req(1'b1);
      if (TX_REQ !== 1'b1) fin = 1;
      else begin
        w = {TX_ADDR, TX_DATA, TX_PEND, PRIORITY};
        if (nobs < 32) obs_w[nobs] = w;
        nobs++;
        repeat ($urandom_range(0, 2)) begin
          @(negedge clk);
          if (TX_REQ !== 1'b1 || {TX_ADDR, TX_DATA, TX_PEND, PRIORITY} !== w) stab_err++;
        end
        TX_ACK = 1;
        @(negedge clk);
        if (TX_REQ !== 1'b0) stab_err++;
        repeat ($urandom_range(0, 2)) begin
          @(negedge clk);
          if (TX_REQ !== 1'b0 || {TX_ADDR, TX_DATA, TX_PEND, PRIORITY} !== w) stab_err++;
        end
        TX_ACK = 0;
        if (nobs == fail_after) begin
          TX_FAIL = 1; resp_hs(); fin = 1;
        end else if (!w.pend) begin
          cyc($urandom_range(0, 2));
          TX_FAIL = end_fail;
          TX_SUCC = end_fail ? 1'($urandom_range(0, 1)) : 1'b1;
          resp_hs(); fin = 1;
        end
      end
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (IN_READY !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b expected 1", IN_READY); end
    checks++; if (TX_REQ !== 1'b0 || TX_RESP_ACK !== 1'b0) begin errors++; $display("FAIL reset_req got req=%b rack=%b expected 0", TX_REQ, TX_RESP_ACK); end
    checks++; if (BUSY !== 1'b0 || MSG_DONE !== 1'b0 || MSG_FAIL !== 1'b0) begin errors++; $display("FAIL reset_status got %b%b%b expected 000", BUSY, MSG_DONE, MSG_FAIL); end
    checks++; if (SUCC_CNT !== '0 || FAIL_CNT !== '0) begin errors++; $display("FAIL reset_counters got %0d/%0d expected 0/0", SUCC_CNT, FAIL_CNT); end
    checks++; if ({TX_ADDR, TX_DATA, TX_PEND, PRIORITY} !== '0) begin errors++; $display("FAIL reset_tx_regs got %h/%h expected 0", TX_ADDR, TX_DATA); end
  endtask

  task automatic test_single();
    push_word(32'h0000_0012, 32'hDEAD_BEEF, 1'b1, 1'b0);
    checks++; if (TX_REQ !== 1'b0) begin errors++; $display("FAIL single_early_req got %b expected 0", TX_REQ); end
    cyc(1);
    checks++; if (TX_REQ !== 1'b1 || BUSY !== 1'b1) begin errors++; $display("FAIL single_req got req=%b busy=%b expected 1,1", TX_REQ, BUSY); end
    checks++; if ({TX_ADDR, TX_DATA, TX_PEND} !== {32'h12, 32'hDEAD_BEEF, 1'b0}) begin errors++; $display("FAIL single_word got %h %h %b expected 12 deadbeef 0", TX_ADDR, TX_DATA, TX_PEND); end
    TX_ACK = 1; cyc(1);
    checks++; if (TX_REQ !== 1'b0) begin errors++; $display("FAIL single_ack_drop got %b expected 0", TX_REQ); end
    TX_ACK = 0; cyc(1);
    TX_SUCC = 1; cyc(1);
    checks++; if (TX_RESP_ACK !== 1'b1) begin errors++; $display("FAIL single_rack_rise got %b expected 1", TX_RESP_ACK); end
    TX_SUCC = 0; cyc(1);
    if (succ_m < CMAX) succ_m++;
    checks++; if (TX_RESP_ACK !== 1'b0 || MSG_DONE !== 1'b1 || MSG_FAIL !== 1'b0) begin errors++; $display("FAIL single_done got rack=%b done=%b fail=%b expected 0,1,0", TX_RESP_ACK, MSG_DONE, MSG_FAIL); end
    checks++; if (SUCC_CNT !== CW'(succ_m)) begin errors++; $display("FAIL single_succ_cnt got %0d expected %0d", SUCC_CNT, succ_m); end
    cyc(1);
    checks++; if (MSG_DONE !== 1'b0 || BUSY !== 1'b0) begin errors++; $display("FAIL single_pulse got done=%b busy=%b expected 0,0", MSG_DONE, BUSY); end
    void'(exp_q.pop_front());
    done_log.delete();
  endtask

  task automatic test_three_word();
    for (int i = 0; i < 3; i++) push_word($urandom, $urandom, i == 2, 1'b1);
    wrapper_serve(0, 1'b0);
    checks++; if (nobs !== 3) begin errors++; $display("FAIL three_count got %0d expected 3", nobs); end
    for (int i = 0; i < 3 && i < nobs; i++) begin
      checks++; if (obs_w[i] !== exp_q[i]) begin errors++; $display("FAIL three_word%0d got %h expected %h", i, obs_w[i], exp_q[i]); end
    end
    repeat (3) if (exp_q.size() > 0) void'(exp_q.pop_front());
    cyc(3);
    if (succ_m < CMAX) succ_m++;
    checks++; if (done_log.size() !== 1 || done_log[0] !== 1'b0) begin errors++; $display("FAIL three_done got %0d pulses expected 1 success", done_log.size()); end
    checks++; if (SUCC_CNT !== CW'(succ_m)) begin errors++; $display("FAIL three_succ_cnt got %0d expected %0d", SUCC_CNT, succ_m); end
    checks++; if (stab_err !== 0) begin errors++; $display("FAIL three_stability got %0d violations expected 0", stab_err); end
    done_log.delete();
  endtask

  task automatic test_mid_fail();
    for (int i = 0; i < 4; i++) push_word($urandom, $urandom, i == 3, 1'b0);
    wrapper_serve(2, 1'b0);
    checks++; if (nobs !== 2) begin errors++; $display("FAIL midfail_count got %0d expected 2", nobs); end
    for (int i = 0; i < 2 && i < nobs; i++) begin
      checks++; if (obs_w[i] !== exp_q[i]) begin errors++; $display("FAIL midfail_word%0d got %h expected %h", i, obs_w[i], exp_q[i]); end
    end
    repeat (4) if (exp_q.size() > 0) void'(exp_q.pop_front());
    cyc(6);
    if (fail_m < CMAX) fail_m++;
    checks++; if (done_log.size() !== 1 || done_log[0] !== 1'b1) begin errors++; $display("FAIL midfail_done got %0d pulses expected 1 failure", done_log.size()); end
    checks++; if (FAIL_CNT !== CW'(fail_m) || BUSY !== 1'b0) begin errors++; $display("FAIL midfail_cnt got %0d busy=%b expected %0d busy=0", FAIL_CNT, BUSY, fail_m); end
    done_log.delete();
    push_word(32'h55, 32'hCAFE_F00D, 1'b1, 1'b1);
    wrapper_serve(0, 1'b0);
    checks++; if (nobs !== 1 || obs_w[0] !== exp_q[0]) begin errors++; $display("FAIL midfail_next got n=%0d %h expected 1 %h", nobs, obs_w[0], exp_q[0]); end
    void'(exp_q.pop_front());
    cyc(3);
    if (succ_m < CMAX) succ_m++;
    checks++; if (SUCC_CNT !== CW'(succ_m) || done_log.size() !== 1) begin errors++; $display("FAIL midfail_next_cnt got %0d expected %0d", SUCC_CNT, succ_m); end
    done_log.delete();
  endtask

  task automatic test_long_message();
    for (int i = 0; i < 7; i++) push_word($urandom, $urandom, 1'b0, 1'b0);
    cyc(2);
    checks++; if (TX_REQ !== 1'b0) begin errors++; $display("FAIL long_partial_req got %b expected 0", TX_REQ); end
    push_word($urandom, $urandom, 1'b0, 1'b0);
    cyc(2);
    checks++; if (TX_REQ !== 1'b1 || IN_READY !== 1'b0) begin errors++; $display("FAIL long_full_start got req=%b rdy=%b expected 1,0", TX_REQ, IN_READY); end
    fork
      begin
        push_word($urandom, $urandom, 1'b0, 1'b0);
        push_word($urandom, $urandom, 1'b1, 1'b0);
      end
      wrapper_serve(0, 1'b0);
    join
    checks++; if (nobs !== 10) begin errors++; $display("FAIL long_count got %0d expected 10", nobs); end
    for (int i = 0; i < 10 && i < nobs; i++) begin
      checks++; if (obs_w[i] !== exp_q[i]) begin errors++; $display("FAIL long_word%0d got %h expected %h", i, obs_w[i], exp_q[i]); end
    end
    repeat (10) if (exp_q.size() > 0) void'(exp_q.pop_front());
    cyc(3);
    if (succ_m < CMAX) succ_m++;
    checks++; if (done_log.size() !== 1 || SUCC_CNT !== CW'(succ_m)) begin errors++; $display("FAIL long_done got %0d pulses cnt %0d expected 1 cnt %0d", done_log.size(), SUCC_CNT, succ_m); end
    done_log.delete();
  endtask

  task automatic test_random();
    int len, mode, fa, nexp; bit ef, fl;
    for (int m = 0; m < 25; m++) begin
      len  = $urandom_range(1, 8);
      mode = $urandom_range(0, 2);
      fa   = (mode == 2 && len > 1) ? $urandom_range(1, len - 1) : 0;
      ef   = (mode != 0) && (fa == 0);
      for (int i = 0; i < len; i++) push_word($urandom, $urandom, i == len - 1, 1'($urandom_range(0, 1)));
      wrapper_serve(fa, ef);
      nexp = (fa != 0) ? fa : len;
      fl   = (mode != 0);
      checks++; if (nobs !== nexp) begin errors++; $display("FAIL rand%0d_count got %0d expected %0d", m, nobs, nexp); end
      for (int i = 0; i < nexp && i < nobs; i++) begin
        checks++; if (obs_w[i] !== exp_q[i]) begin errors++; $display("FAIL rand%0d_word%0d got %h expected %h", m, i, obs_w[i], exp_q[i]); end
      end
      repeat (len) if (exp_q.size() > 0) void'(exp_q.pop_front());
      cyc(len + 4);
      if (fl) begin if (fail_m < CMAX) fail_m++; end
      else begin if (succ_m < CMAX) succ_m++; end
      checks++; if (done_log.size() !== 1 || done_log[0] !== fl) begin errors++; $display("FAIL rand%0d_done got %0d pulses expected 1 with fail=%b", m, done_log.size(), fl); end
      checks++; if (SUCC_CNT !== CW'(succ_m) || FAIL_CNT !== CW'(fail_m)) begin errors++; $display("FAIL rand%0d_cnt got %0d/%0d expected %0d/%0d", m, SUCC_CNT, FAIL_CNT, succ_m, fail_m); end
      done_log.delete();
    end
    checks++; if (stab_err !== 0) begin errors++; $display("FAIL rand_stability got %0d violations expected 0", stab_err); end
  endtask

  task automatic test_saturation();
    do_reset();
    for (int m = 0; m < 5; m++) begin
      push_word($urandom, $urandom, 1'b1, 1'b0);
      wrapper_serve(0, 1'b0);
      void'(exp_q.pop_front());
      cyc(2);
      if (succ_m < CMAX) succ_m++;
      checks++; if (SUCC_CNT !== CW'(succ_m)) begin errors++; $display("FAIL sat_step%0d got %0d expected %0d", m, SUCC_CNT, succ_m); end
    end
    checks++; if (SUCC_CNT !== 2'd3) begin errors++; $display("FAIL sat_final got %0d expected 3", SUCC_CNT); end
    done_log.delete();
  endtask

  task automatic test_reset_mid_req();
    push_word(32'hA5, 32'h1111_2222, 1'b1, 1'b1);
    cyc(1);
    checks++; if (TX_REQ !== 1'b1) begin errors++; $display("FAIL rst_pre_req got %b expected 1", TX_REQ); end
    push_word(32'hB6, 32'h3333_4444, 1'b1, 1'b0);
    #2 RESETn = 1'b0;
    #1;
    checks++; if (TX_REQ !== 1'b0 || IN_READY !== 1'b1 || BUSY !== 1'b0) begin errors++; $display("FAIL rst_async got req=%b rdy=%b busy=%b expected 0,1,0", TX_REQ, IN_READY, BUSY); end
    @(negedge clk);
    RESETn = 1'b1;
    model_clear();
    cyc(10);
    checks++; if (TX_REQ !== 1'b0 || BUSY !== 1'b0 || MSG_DONE !== 1'b0) begin errors++; $display("FAIL rst_stale got req=%b busy=%b done=%b expected 0,0,0", TX_REQ, BUSY, MSG_DONE); end
  endtask

  initial begin
    RESETn = 1'b0; IN_VALID = 0; IN_LAST = 0; IN_PRIORITY = 0; IN_ADDR = '0; IN_DATA = '0;
    TX_ACK = 0; TX_SUCC = 0; TX_FAIL = 0;
    cyc(1);
    test_reset();
    test_single();
    test_three_word();
    test_mid_fail();
    test_long_message();
    test_random();
    test_saturation();
    test_reset_mid_req();
    checks++; if (tmo_cnt !== 0) begin errors++; $display("FAIL handshake_timeouts got %0d expected 0", tmo_cnt); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
